// File: rtl/hvac_stage_ctrl.sv
// hvac_stage_ctrl: turns raw heat/cool/fan request bits from the Wishbone output
// register into relay drive. It enforces minimum on-time, anti-short-cycle
// lockout, fan post-purge and heat/cool mutual exclusion.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   LOCKOUT | compressor/burner rest period after reset and after every run
//   IDLE    | waiting for an unambiguous heat or cool request
//   HEAT    | heat relay on, held for at least MIN_ON ticks
//   COOL    | cool relay on, held for at least MIN_ON ticks
//   PURGE   | fan keeps moving air for FAN_LAG ticks after heat/cool drops
module hvac_stage_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int MIN_ON     = 3,
    parameter int MIN_OFF    = 5,
    parameter int FAN_LAG    = 2,
    parameter int TIME_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_heat,
    input  logic                 req_cool,
    input  logic                 req_fan,
    output logic                 heat_on,
    output logic                 cool_on,
    output logic                 fan_on,
    output logic                 lockout,
    output logic                 conflict,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] starts
);

    typedef enum logic [2:0] {
        ST_LOCKOUT = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HEAT    = 3'd2,
        ST_COOL    = 3'd3,
        ST_PURGE   = 3'd4
    } state_t;

    localparam logic [TIME_WIDTH-1:0] T_MIN_ON   = TIME_WIDTH'(MIN_ON);
    localparam logic [TIME_WIDTH-1:0] T_MIN_OFF  = TIME_WIDTH'(MIN_OFF);
    localparam logic [TIME_WIDTH-1:0] T_FAN_LAG  = TIME_WIDTH'(FAN_LAG);
    localparam logic [TIME_WIDTH-1:0] T_DIV_LAST = TIME_WIDTH'(CLK_DIV - 1);

    state_t                state_q;
    state_t                state_d;
    logic [TIME_WIDTH-1:0] timer_q;
    logic [TIME_WIDTH-1:0] timer_d;
    logic [TIME_WIDTH-1:0] presc_q;
    logic [TIME_WIDTH-1:0] presc_d;
    logic [CNT_WIDTH-1:0]  starts_q;
    logic                  start_pulse;

    // State, dwell timer and tick prescaler registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOCKOUT;
            timer_q <= T_MIN_OFF;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
        end
    end

    // Timer countdown while dwelling; transitions only once the dwell has expired.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        presc_d     = presc_q;
        start_pulse = 1'b0;
        if (timer_q != '0) begin
            if (presc_q == T_DIV_LAST) begin
                presc_d = '0;
                timer_d = timer_q - 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else begin
            presc_d = '0;
            unique case (state_q)
                ST_LOCKOUT: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
                ST_IDLE: begin
                    if (req_heat && !req_cool) begin
                        state_d     = ST_HEAT;
                        timer_d     = T_MIN_ON;
                        start_pulse = 1'b1;
                    end else if (req_cool && !req_heat) begin
                        state_d     = ST_COOL;
                        timer_d     = T_MIN_ON;
                        start_pulse = 1'b1;
                    end
                end
                ST_HEAT: begin
                    // A cool request while heating also ends the run: mode
                    // changes always go through purge and lockout.
                    if (!req_heat || req_cool) begin
                        state_d = ST_PURGE;
                        timer_d = T_FAN_LAG;
                    end
                end
                ST_COOL: begin
                    if (!req_cool || req_heat) begin
                        state_d = ST_PURGE;
                        timer_d = T_FAN_LAG;
                    end
                end
                ST_PURGE: begin
                    state_d = ST_LOCKOUT;
                    timer_d = T_MIN_OFF;
                end
                default: begin
                    state_d = ST_LOCKOUT;
                    timer_d = T_MIN_OFF;
                end
            endcase
        end
    end

    // Start counter, saturating so software never sees a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starts_q <= '0;
        end else if (start_pulse && (starts_q != '1)) begin
            starts_q <= starts_q + 1'b1;
        end
    end

    // Relay drive is decoded from the state register, so an async reset drops
    // heat/cool immediately. The manual fan request bypasses the state machine.
    assign heat_on  = (state_q == ST_HEAT);
    assign cool_on  = (state_q == ST_COOL);
    assign fan_on   = req_fan || (state_q == ST_HEAT) || (state_q == ST_COOL)
                      || (state_q == ST_PURGE);
    assign lockout  = (state_q == ST_LOCKOUT);
    assign conflict = (state_q == ST_IDLE) && req_heat && req_cool;
    assign state    = state_q;
    assign starts   = starts_q;

endmodule

// File: tb/tb_hvac_stage_ctrl.sv
// Directed testbench for hvac_stage_ctrl with default timing plus a second
// instance with a 2-bit start counter for the saturation case.
module tb_hvac_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_heat = 1'b0;
    logic        req_cool = 1'b0;
    logic        req_fan = 1'b0;
    logic        heat_on, cool_on, fan_on, lockout, conflict;
    logic [2:0]  state;
    logic [15:0] starts;

    logic        b_reset = 1'b1;
    logic        b_req_heat = 1'b0;
    logic        b_heat_on, b_cool_on, b_fan_on, b_lockout, b_conflict;
    logic [2:0]  b_state;
    logic [1:0]  b_starts;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hvac_stage_ctrl dut (
        .clk(clk), .reset(reset),
        .req_heat(req_heat), .req_cool(req_cool), .req_fan(req_fan),
        .heat_on(heat_on), .cool_on(cool_on), .fan_on(fan_on),
        .lockout(lockout), .conflict(conflict), .state(state), .starts(starts)
    );

    hvac_stage_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(b_reset),
        .req_heat(b_req_heat), .req_cool(1'b0), .req_fan(1'b0),
        .heat_on(b_heat_on), .cool_on(b_cool_on), .fan_on(b_fan_on),
        .lockout(b_lockout), .conflict(b_conflict), .state(b_state), .starts(b_starts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts consecutive negedge samples (current one included) where the
    // selected condition holds: 0 heat_on, 1 cool_on, 2 PURGE, 3 lockout.
    task automatic run_len(input int sel, output int n);
        logic c;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            case (sel)
                0:       c = heat_on;
                1:       c = cool_on;
                2:       c = (state == 3'd4);
                default: c = lockout;
            endcase
            if (!c) break;
            n++;
            step(1);
        end
    endtask

    initial begin
        int n;
        int k;
        logic both;
        int exp_s[5];
        exp_s = '{1, 2, 3, 3, 3};

        // Power-up lockout
        req_heat = 1'b1;
        step(2);
        check("rst_state", state, 0);
        check("rst_lockout", lockout, 1);
        check("rst_heat", heat_on, 0);
        check("rst_fan", fan_on, 0);
        check("rst_starts", starts, 0);
        check("rst_conflict", conflict, 0);
        req_fan = 1'b1;
        #1 check("rst_fan_req", fan_on, 1);
        req_fan = 1'b0;
        step(1);
        reset = 1'b0;
        step(20);
        check("pu_lockout_20", lockout, 1);
        check("pu_state_20", state, 0);
        step(1);
        check("pu_idle_21", state, 1);
        check("pu_heat_21", heat_on, 0);
        step(1);
        check("pu_heat_22", heat_on, 1);
        check("pu_state_22", state, 2);
        check("pu_starts", starts, 1);
        check("pu_fan", fan_on, 1);

        // Minimum on-time, purge, lockout
        step(2);
        req_heat = 1'b0;
        run_len(0, n);
        check("minon_heat_len", n + 2, 13);
        check("purge_heat_off", heat_on, 0);
        check("purge_fan_on", fan_on, 1);
        run_len(2, n);
        check("purge_len", n, 9);
        run_len(3, n);
        check("lockout_len", n, 21);
        check("after_lockout_idle", state, 1);

        // Manual fan in IDLE
        req_fan = 1'b1;
        #1 check("fan_follow_on", fan_on, 1);
        check("fan_state_keep", state, 1);
        step(1);
        check("fan_state_keep2", state, 1);
        req_fan = 1'b0;
        #1 check("fan_follow_off", fan_on, 0);
        check("fan_state_keep3", state, 1);

        // Mode change COOL -> HEAT
        step(1);
        req_cool = 1'b1;
        step(1);
        check("cool_on", cool_on, 1);
        check("cool_starts", starts, 2);
        step(14);
        check("cool_held", cool_on, 1);
        req_heat = 1'b1;
        both = 1'b0;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (heat_on && cool_on) both = 1'b1;
            k = i;
            if (state == 3'd1) break;
        end
        check("mc_exclusive", both, 0);
        check("mc_idle_reached", state, 1);
        check("mc_steps", k, 31);
        check("mc_conflict", conflict, 1);
        check("mc_no_heat", heat_on, 0);
        req_cool = 1'b0;
        #1 check("mc_conflict_clr", conflict, 0);
        step(1);
        check("mc_heat_on", heat_on, 1);
        check("mc_state", state, 2);
        check("mc_starts", starts, 3);

        // Async reset mid-HEAT
        step(2);
        #2 reset = 1'b1;
        #1 check("ar_heat_off", heat_on, 0);
        check("ar_fan", fan_on, 0);
        check("ar_state", state, 0);
        check("ar_lockout", lockout, 1);
        check("ar_starts", starts, 0);
        req_fan = 1'b1;
        #1 check("ar_fan_req", fan_on, 1);
        req_fan = 1'b0;
        step(1);
        reset = 1'b0;
        step(20);
        check("ar_lockout_20", lockout, 1);
        step(1);
        check("ar_idle_21", state, 1);
        step(1);
        check("ar_heat_22", heat_on, 1);
        check("ar_starts_1", starts, 1);

        // Counter saturation with a 2-bit counter
        b_req_heat = 1'b1;
        step(1);
        b_reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (k = 0; k < 60 && !b_heat_on; k++) step(1);
            check("sat_heat_wait", b_heat_on, 1);
            check("sat_starts", b_starts, exp_s[c]);
            b_req_heat = 1'b0;
            for (k = 0; k < 60 && !b_lockout; k++) step(1);
            check("sat_lockout_wait", b_lockout, 1);
            b_req_heat = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
